serv_shift_stage: RTL and testbench
===================================

# serv_shift_stage

Bit-serial shift stage that sits directly upstream of the ALU and drives the ALU's `i_buf` operand. It loads a 32-bit operand W bits per beat during the init pass and captures the 5-bit shift amount. It then aligns the operand one bit per cycle for SLL/SRL/SRA. On the following execute pass it streams the shifted result LSB-first. Outside that pass its output is forced to zero, so the ALU can OR it unconditionally into `o_rd`.

## Interface
- `W`, default 1: datapath width per beat; legal values 1 and 4.
- `B`, default W-1: MSB index of per-beat buses.

Ports:
- `clk`, in, 1: single clock; all state updates on rising edge.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_en`, in, 1: beat enable; no beat occurs when low, and all state holds.
- `i_cnt0`, in, 1: first beat of a 32-bit pass.
- `i_cnt_done`, in, 1: last beat of a 32-bit pass (beat 32/W-1).
- `i_init`, in, 1: init pass; a beat with `i_init` high is a load beat, with it low an output beat.
- `i_right`, in, 1: 1 selects right shift, 0 selects left shift; sampled at the last load beat.
- `i_signed`, in, 1: arithmetic right shift; ignored when `i_right`=0; sampled at the last load beat.
- `i_rs1`, in, [B:0]: operand bits, LSB-first.
- `i_op_b`, in, [B:0]: shift-amount source; bits 0..4 of the word are used.
- `o_sh_done`, out, 1: alignment complete and result ready for the output pass.
- `o_q`, out, [B:0]: result bits to ALU `i_buf`; zero whenever no output beat is active.

## Operation
- States: IDLE, LOAD, ALIGN, DONE.
- IDLE/DONE -> LOAD: on `i_en & i_init & i_cnt0`.
- LOAD:
  - Each beat shifts the 32-bit data register right by W, with `i_rs1` entering at bits [31:32-W].
  - The internal beat counter resets on `i_cnt0`.
  - Word bits 0..4 of `i_op_b` go into `shamt`. For W=1 these are beats 0-4. For W=4 they are beat 0 bits [3:0] and beat 1 bit 0.
  - `i_right`/`i_signed` are latched on the `i_cnt_done` beat.
  - Exit on the `i_cnt_done` beat: to ALIGN if `shamt`≠0, else to DONE.
- ALIGN:
  - Advances one bit per clock and is independent of `i_en`.
  - Right shift: the data register shifts right 1. The fill bit is `data[31]` when signed, else 0.
  - Left shift: the data register shifts left 1 with fill 0.
  - `shamt` decrements each cycle. When it reaches 0, the next state is DONE.
- DONE:
  - `o_sh_done`=1.
  - Each `i_en & ~i_init` beat drives `o_q = data[B:0]` and shifts data right by W, with zero fill.
  - The `i_cnt_done` output beat returns to IDLE.
- `o_q` = 0 in every other state and beat.
- Reset values: state IDLE, data 0, `shamt` 0, latched mode 0, `o_sh_done` 0, `o_q` 0.
- Boundaries:
  - `shamt`=0: the result equals `rs1` exactly.
  - `shamt`=31 SRA of a negative value yields 0xFFFFFFFF; SRL of 0x80000000 yields 1.
  - `i_init` beats during ALIGN are ignored and do not restart the load.
  - `i_en` low during LOAD or an output pass holds all state; the pass resumes on the next enabled beat.
  - An output beat while in IDLE/LOAD/ALIGN gives `o_q`=0 and changes no state.
  - `i_rst` at any point, including mid-ALIGN or mid-output, forces IDLE on the next edge, with `o_sh_done` low from then.
  - Simultaneous `i_rst` and `i_cnt0` load: reset wins.

## Timing
- Load: 32/W enabled beats.
- Alignment latency: `o_sh_done` rises `shamt`+1 clocks after the edge that consumes the last load beat. For `shamt`=0 this is 1 clock.
- Output: `o_q` is combinational from registered data, qualified by state/`i_en`/`i_init`. Beat k carries result bits [kW+B:kW].
- `o_sh_done` falls on the edge consuming the `i_cnt_done` output beat.
- No combinational path from `i_rs1`/`i_op_b` to any output.

## Structure
- Shared package `serv_shift_pkg` holds:
  - state enum (IDLE, LOAD, ALIGN, DONE);
  - `XLEN`=32;
  - `SHAMT_W`=5;
  - `BEATS(W)`=32/W.
- Sub-module `serv_shamt_counter`: a 5-bit loadable down-counter with serial/nibble capture, decrement and zero flag. Everything else stays in the top level.

## Test plan
- W=1, SLL `rs1`=0x0000_00F1, `shamt`=4 -> `o_sh_done` 5 clocks after load; output stream 0x0000_0F10.
- W=4, SRA `rs1`=0x8000_0000, `shamt`=31 -> 8 output beats of 0xF, word 0xFFFF_FFFF. The same operation as SRL -> 0x0000_0001.
- W=1, `shamt`=0, `rs1`=0xDEAD_BEEF -> `o_sh_done` 1 clock after load; output 0xDEAD_BEEF.
- Output beats issued before `o_sh_done` and while IDLE -> `o_q`=0 every beat, state unchanged.
- `i_en` toggled randomly during load and output, SRL 0x1234_5678 by 8 -> output 0x0012_3456.
- `i_rst` mid-ALIGN (`shamt`=20, cycle 10) -> IDLE next clock, `o_sh_done`=0, `o_q`=0. A subsequent SLL 1 by 1 yields 0x0000_0002.

Source files
------------

// File: rtl/serv_shift_pkg.sv
// serv_shift_pkg: shared state encoding and sizes for the serial shift stage
package serv_shift_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, ALIGN, DONE} state_t;
  localparam int XLEN = 32;
  localparam int SHAMT_W = 5;
  function automatic int BEATS(int w);
    return XLEN / w;
  endfunction
endpackage

// File: rtl/serv_shamt_counter.sv
// serv_shamt_counter: shift amount captured serially or by nibble, then counted down
module serv_shamt_counter
  import serv_shift_pkg::*;
#(
  parameter int W = 1,
  parameter int B = W - 1
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic               i_cap,
  input  logic [4:0]         i_idx,
  input  logic [B:0]         i_d,
  input  logic               i_dec,
  output logic [SHAMT_W-1:0] o_q,
  output logic               o_zero
);
  logic [SHAMT_W-1:0] r_q, w_cap;
  generate
    if (W == 1) begin : g_serial
      always_comb begin
        w_cap = r_q;
        if (i_idx == 5'd0) w_cap = {4'b0, i_d[0]};
        else if (i_idx < 5'd5) w_cap[i_idx[2:0]] = i_d[0];
      end
    end else begin : g_nibble
      always_comb w_cap = (i_idx == 5'd0) ? {1'b0, i_d[3:0]} :
                          (i_idx == 5'd1) ? {i_d[0], r_q[3:0]} : r_q;
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (i_rst) r_q <= '0;
    else if (i_cap) r_q <= w_cap;
    else if (i_dec) r_q <= r_q - SHAMT_W'(1);
  end
  assign o_q = r_q;
  assign o_zero = (r_q == '0);
endmodule

// File: rtl/serv_shift_stage.sv
// serv_shift_stage: loads an operand serially, aligns it one bit per clock,
// then streams the shifted word LSB-first into the ALU buffer input
module serv_shift_stage
  import serv_shift_pkg::*;
#(
  parameter int W = 1,
  parameter int B = W - 1
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_cnt0,
  input  logic       i_cnt_done,
  input  logic       i_init,
  input  logic       i_right,
  input  logic       i_signed,
  input  logic [B:0] i_rs1,
  input  logic [B:0] i_op_b,
  output logic       o_sh_done,
  output logic [B:0] o_q
);
  state_t r_state, w_next;
  logic [XLEN-1:0] r_data;
  logic [4:0] r_beat, w_idx;
  logic r_right, r_signed;
  logic [SHAMT_W-1:0] w_shamt;
  logic w_zero, w_rest, w_load, w_align, w_out;
  assign w_rest = (r_state == IDLE) || (r_state == DONE);
  assign w_load = i_en & i_init & ((r_state == LOAD) | (w_rest & i_cnt0));
  assign w_align = (r_state == ALIGN);
  assign w_out = i_en & ~i_init & (r_state == DONE);
  assign w_idx = i_cnt0 ? 5'd0 : r_beat;
  serv_shamt_counter #(.W(W)) u_shamt (
    .clk(clk), .i_rst(i_rst), .i_cap(w_load), .i_idx(w_idx), .i_d(i_op_b),
    .i_dec(w_align), .o_q(w_shamt), .o_zero(w_zero)
  );
  // leaving ALIGN on the decrement that reaches zero keeps latency at shamt+1
  always_comb w_next = w_load ? (i_cnt_done ? (w_zero ? DONE : ALIGN) : LOAD) :
                       w_align ? ((w_shamt == SHAMT_W'(1)) ? DONE : ALIGN) :
                       (w_out & i_cnt_done) ? IDLE : r_state;
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_data <= '0;
      r_beat <= '0;
      r_right <= 1'b0;
      r_signed <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_data <= {i_rs1, r_data[XLEN-1:W]};
        r_beat <= w_idx + 5'd1;
        if (i_cnt_done) begin
          r_right <= i_right;
          r_signed <= i_signed & i_right;
        end
      end else if (w_align) begin
        r_data <= r_right ? {r_signed & r_data[XLEN-1], r_data[XLEN-1:1]} : {r_data[XLEN-2:0], 1'b0};
      end else if (w_out) begin
        r_data <= {{W{1'b0}}, r_data[XLEN-1:W]};
      end
    end
  end
  assign o_sh_done = (r_state == DONE);
  assign o_q = w_out ? r_data[B:0] : '0;
endmodule

// File: tb/tb_serv_shift_stage.sv
// tb_serv_shift_stage: directed checks of a W=1 and a W=4 shift stage
module tb_serv_shift_stage;
  import serv_shift_pkg::*;
  logic clk = 0, rst = 1, en1 = 0, en4 = 0, cnt0 = 0, cnt_done = 0, init = 0, right = 0, sgn = 0;
  logic [0:0] rs1_1 = '0, opb_1 = '0, q1;
  logic [3:0] rs1_4 = '0, opb_4 = '0, q4;
  logic d1, d4;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  serv_shift_stage #(.W(1)) u1 (
    .clk(clk), .i_rst(rst), .i_en(en1), .i_cnt0(cnt0), .i_cnt_done(cnt_done), .i_init(init),
    .i_right(right), .i_signed(sgn), .i_rs1(rs1_1), .i_op_b(opb_1), .o_sh_done(d1), .o_q(q1)
  );
  serv_shift_stage #(.W(4)) u4 (
    .clk(clk), .i_rst(rst), .i_en(en4), .i_cnt0(cnt0), .i_cnt_done(cnt_done), .i_init(init),
    .i_right(right), .i_signed(sgn), .i_rs1(rs1_4), .i_op_b(opb_4), .o_sh_done(d4), .o_q(q4)
  );

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_rnd(bit rnd);
    if (rnd) for (int i = 0; i < 3 && $urandom_range(0, 1) == 1; i++) begin
      en1 = 0; en4 = 0;
      step();
    end
  endtask

  task automatic load(int w, logic [31:0] rs1, logic [4:0] sh, logic r, logic s, bit rnd);
    logic [31:0] t, b;
    int n = BEATS(w);
    right = r; sgn = s;
    for (int k = 0; k < n; k++) begin
      idle_rnd(rnd);
      t = rs1 >> (k * w);
      b = {27'b0, sh} >> (k * w);
      rs1_1 = t[0]; rs1_4 = t[3:0]; opb_1 = b[0]; opb_4 = b[3:0];
      en1 = (w == 1); en4 = (w == 4); init = 1; cnt0 = (k == 0); cnt_done = (k == n - 1);
      step();
    end
    en1 = 0; en4 = 0; init = 0; cnt0 = 0; cnt_done = 0;
  endtask

  task automatic wait_done(int w, output int lat);
    lat = 1;
    while (!(w == 1 ? d1 : d4) && lat < 200) begin
      step();
      lat++;
    end
  endtask

  task automatic unload(int w, bit rnd, output logic [31:0] res, output bit all_f);
    logic [3:0] q;
    int n = BEATS(w);
    res = '0; all_f = 1;
    for (int k = 0; k < n; k++) begin
      idle_rnd(rnd);
      en1 = (w == 1); en4 = (w == 4); init = 0; cnt0 = (k == 0); cnt_done = (k == n - 1);
      #1;
      q = (w == 1) ? {3'b0, q1} : q4;
      res = res | ({28'b0, q} << (k * w));
      all_f = all_f & (q == 4'hF);
      step();
    end
    en1 = 0; en4 = 0; cnt0 = 0; cnt_done = 0;
  endtask

  initial begin
    int lat;
    logic [31:0] res;
    bit all_f, zero_ok;
    repeat (3) step();
    rst = 0;
    en1 = 1; en4 = 1; init = 0;
    #1;
    check("reset_done1", {31'b0, d1}, 0);
    check("reset_done4", {31'b0, d4}, 0);
    check("reset_q1", {31'b0, q1}, 0);
    check("reset_q4", {28'b0, q4}, 0);
    en1 = 0; en4 = 0;
    step();

    load(1, 32'h0000_00F1, 5'd4, 0, 0, 0);
    wait_done(1, lat);
    check("sll4_latency", lat, 5);
    unload(1, 0, res, all_f);
    check("sll4_result", res, 32'h0000_0F10);
    check("sll4_done_fall", {31'b0, d1}, 0);

    load(4, 32'h8000_0000, 5'd31, 1, 1, 0);
    wait_done(4, lat);
    check("sra31_latency", lat, 32);
    unload(4, 0, res, all_f);
    check("sra31_result", res, 32'hFFFF_FFFF);
    check("sra31_beats_f", {31'b0, all_f}, 1);
    check("sra31_done_fall", {31'b0, d4}, 0);

    load(4, 32'h8000_0000, 5'd31, 1, 0, 0);
    wait_done(4, lat);
    unload(4, 0, res, all_f);
    check("srl31_result", res, 32'h0000_0001);

    load(1, 32'hDEAD_BEEF, 5'd0, 1, 1, 0);
    wait_done(1, lat);
    check("sh0_latency", lat, 1);
    unload(1, 0, res, all_f);
    check("sh0_result", res, 32'hDEAD_BEEF);

    zero_ok = 1;
    for (int k = 0; k < 32; k++) begin
      en1 = 1; init = 0; cnt0 = (k == 0); cnt_done = (k == 31);
      #1;
      zero_ok = zero_ok & (q1 == 1'b0);
      step();
    end
    en1 = 0; cnt0 = 0; cnt_done = 0;
    check("idle_out_zero", {31'b0, zero_ok}, 1);
    check("idle_out_no_done", {31'b0, d1}, 0);

    load(1, 32'hF000_0000, 5'd4, 1, 0, 0);
    zero_ok = 1;
    for (int k = 0; k < 2; k++) begin
      en1 = 1; init = 0; cnt0 = (k == 0); cnt_done = (k == 1);
      #1;
      zero_ok = zero_ok & (q1 == 1'b0);
      step();
    end
    en1 = 1; init = 1; cnt0 = 1; cnt_done = 0; rs1_1 = 1'b1;
    step();
    en1 = 0; init = 0; cnt0 = 0;
    check("align_out_zero", {31'b0, zero_ok}, 1);
    wait_done(1, lat);
    check("align_done", {31'b0, d1}, 1);
    unload(1, 0, res, all_f);
    check("align_ignored_result", res, 32'h0F00_0000);

    load(1, 32'h1234_5678, 5'd8, 1, 0, 1);
    wait_done(1, lat);
    check("rnd_en_latency", lat, 9);
    unload(1, 1, res, all_f);
    check("rnd_en_result", res, 32'h0012_3456);

    load(1, 32'h0000_0001, 5'd20, 0, 0, 0);
    repeat (10) step();
    rst = 1;
    step();
    rst = 0;
    check("rst_align_done", {31'b0, d1}, 0);
    en1 = 1; init = 0;
    #1;
    check("rst_align_q", {31'b0, q1}, 0);
    en1 = 0;
    repeat (30) step();
    check("rst_align_stays_idle", {31'b0, d1}, 0);
    load(1, 32'h0000_0001, 5'd1, 0, 0, 0);
    wait_done(1, lat);
    unload(1, 0, res, all_f);
    check("post_rst_sll1", res, 32'h0000_0002);

    rst = 1; en1 = 1; init = 1; cnt0 = 1; cnt_done = 0; rs1_1 = 1'b1; opb_1 = 1'b0;
    step();
    rst = 0; cnt0 = 0;
    for (int k = 1; k < 32; k++) begin
      cnt_done = (k == 31);
      step();
    end
    en1 = 0; init = 0; cnt_done = 0;
    step();
    check("rst_beats_cnt0", {31'b0, d1}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
